wb_timer: RTL

Wishbone classic slave timer/compare peripheral that sits directly downstream of the AXI4-Lite-to-Wishbone bridge and serves its single-beat reads and writes. It provides a 32-bit up-counter with an 8-bit prescaler, a compare register, optional auto-reload and a level interrupt. The bridge holds STB/CYC until ACK, so this block must return exactly one single-cycle ACK per access and must never stall.

---
 rtl/wb_timer_if.sv | 27 ++
 rtl/wb_timer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/wb_timer_if.sv
// Wishbone classic bus bundle between the AXI4-Lite bridge (master) and wb_timer (slave).
// Signal names keep the slave-side suffixes used across the bridge fabric.
interface wb_timer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   wb_adr_i;
    logic [DATA_WIDTH-1:0]   wb_dat_i;
    logic [DATA_WIDTH-1:0]   wb_dat_o;
    logic [DATA_WIDTH/8-1:0] wb_sel_i;
    logic                    wb_we_i;
    logic                    wb_cyc_i;
    logic                    wb_stb_i;
    logic                    wb_ack_o;
    logic                    wb_err_o;
    logic                    wb_rty_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );
endinterface

// File: rtl/wb_timer.sv
// Wishbone classic timer: 32-bit up-counter behind an 8-bit prescaler, compare match with
// optional auto-reload, level interrupt. One registered single-cycle ack per access, never stalls.
module wb_timer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic      clk_i,
    input  logic      rst_i,
    wb_timer_if.slave bus,
    output logic      irq_o
);
    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_COUNT   = 2'd1;
    localparam logic [1:0] REG_COMPARE = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    typedef enum logic {
        S_IDLE,
        S_ACK
    } state_t;

    state_t                state;
    logic                  ack;
    logic [DATA_WIDTH-1:0] dat_out;

    logic                  en;
    logic                  auto_reload;
    logic                  ie;
    logic [7:0]            prescale;
    logic [7:0]            pre_cnt;
    logic [DATA_WIDTH-1:0] count;
    logic [DATA_WIDTH-1:0] compare;
    logic                  match;

    logic                  access;
    logic                  wr;
    logic [1:0]            reg_sel;
    logic                  tick;
    logic                  hit;
    logic                  status_clr;
    logic [DATA_WIDTH-1:0] ctrl_wr;
    logic [DATA_WIDTH-1:0] rd_data;

    // Only adr[3:2] is decoded; the remaining address bits alias the map every 16 bytes.
    logic unused_adr;
    assign unused_adr = ^{bus.wb_adr_i[ADDR_WIDTH-1:4], bus.wb_adr_i[1:0]};

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0]   old_val,
        input logic [DATA_WIDTH-1:0]   new_val,
        input logic [DATA_WIDTH/8-1:0] sel
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_val;
        for (int b = 0; b < DATA_WIDTH/8; b++) begin
            if (sel[b]) begin
                res[b*8 +: 8] = new_val[b*8 +: 8];
            end
        end
        return res;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] ctrl_word(
        input logic       f_en,
        input logic       f_ar,
        input logic       f_ie,
        input logic [7:0] f_pre
    );
        logic [DATA_WIDTH-1:0] w;
        w        = '0;
        w[0]     = f_en;
        w[1]     = f_ar;
        w[2]     = f_ie;
        w[15:8]  = f_pre;
        return w;
    endfunction

    always_comb begin
        access     = (state == S_IDLE) && bus.wb_cyc_i && bus.wb_stb_i;
        wr         = access && bus.wb_we_i;
        reg_sel    = bus.wb_adr_i[3:2];
        tick       = en && (pre_cnt == prescale);
        hit        = tick && (count == compare);
        status_clr = wr && (reg_sel == REG_STATUS) && bus.wb_sel_i[0] && bus.wb_dat_i[0];
        ctrl_wr    = merge_bytes(ctrl_word(en, auto_reload, ie, prescale),
                                 bus.wb_dat_i, bus.wb_sel_i);
        rd_data    = '0;
        case (reg_sel)
            REG_CTRL:    rd_data = ctrl_word(en, auto_reload, ie, prescale);
            REG_COUNT:   rd_data = count;
            REG_COMPARE: rd_data = compare;
            REG_STATUS:  rd_data[0] = match;
            default:     rd_data = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            ack         <= 1'b0;
            dat_out     <= '0;
            en          <= 1'b0;
            auto_reload <= 1'b0;
            ie          <= 1'b0;
            prescale    <= 8'd0;
            pre_cnt     <= 8'd0;
            count       <= '0;
            compare     <= '1;
            match       <= 1'b0;
        end else begin
            // Access FSM: read data is captured from pre-edge state, writes commit here too.
            case (state)
                S_IDLE: begin
                    if (access) begin
                        state   <= S_ACK;
                        ack     <= 1'b1;
                        dat_out <= bus.wb_we_i ? '0 : rd_data;
                    end
                end
                S_ACK: begin
                    state   <= S_IDLE;
                    ack     <= 1'b0;
                    dat_out <= '0;
                end
                default: begin
                    state   <= S_IDLE;
                    ack     <= 1'b0;
                    dat_out <= '0;
                end
            endcase

            if (!en || tick) begin
                pre_cnt <= 8'd0;
            end else begin
                pre_cnt <= pre_cnt + 8'd1;
            end

            // A bus write to COUNT overrides the tick update in the same cycle.
            if (wr && (reg_sel == REG_COUNT)) begin
                count <= merge_bytes(count, bus.wb_dat_i, bus.wb_sel_i);
            end else if (tick) begin
                count <= (hit && auto_reload) ? '0 : count + DATA_WIDTH'(1);
            end

            if (wr && (reg_sel == REG_COMPARE)) begin
                compare <= merge_bytes(compare, bus.wb_dat_i, bus.wb_sel_i);
            end

            if (wr && (reg_sel == REG_CTRL)) begin
                en          <= ctrl_wr[0];
                auto_reload <= ctrl_wr[1];
                ie          <= ctrl_wr[2];
                prescale    <= ctrl_wr[15:8];
            end

            // A new match beats a simultaneous clear.
            match <= hit || (match && !status_clr);
        end
    end

    assign bus.wb_ack_o = ack;
    assign bus.wb_dat_o = dat_out;
    assign bus.wb_err_o = 1'b0;
    assign bus.wb_rty_o = 1'b0;
    assign irq_o        = match && ie;

endmodule
